// File: rtl/spi_ram_master.sv
// SPI initiator that turns host write/read requests into SPI_Wrapper 11-bit command frames.
// Defining SPI_RAM_MASTER_ABORT_EN adds an abort input that cancels a transaction in flight.
module spi_ram_master #(
    parameter int GAP_CYCLES = 2,
    parameter int MISO_DLY   = 1
) (
    input  logic       clk,
    input  logic       rst,
`ifdef SPI_RAM_MASTER_ABORT_EN
    input  logic       abort,
`endif
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rw,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       busy,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);
    localparam int SEND_LAST = 11;
    localparam int GAP_LAST  = (GAP_CYCLES < 1) ? 0 : GAP_CYCLES - 1;
    localparam int RESP_LAST = MISO_DLY + 8;
    localparam int MAX_A     = (SEND_LAST > GAP_LAST) ? SEND_LAST : GAP_LAST;
    localparam int CNT_MAX   = (MAX_A > RESP_LAST) ? MAX_A : RESP_LAST;
    localparam int CW        = $clog2(CNT_MAX + 1);

    localparam logic [1:0] PH_ADDR = 2'd0;
    localparam logic [1:0] PH_DATA = 2'd1;
    localparam logic [1:0] PH_RESP = 2'd2;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SEND = 3'd1,
        GAP  = 3'd2,
        RESP = 3'd3,
        DONE = 3'd4
    } state_t;

    // Command byte in the top 3 bits, payload below; read-data frames carry a dummy payload.
    function automatic logic [10:0] build_frame(input logic rw, input logic [1:0] phase,
                                                input logic [7:0] addr, input logic [7:0] wdata);
        logic [10:0] f;
        case ({rw, phase})
            3'b0_00: f = {3'b000, addr};
            3'b0_01: f = {3'b001, wdata};
            3'b1_00: f = {3'b110, addr};
            3'b1_01: f = {3'b111, 8'hFF};
            default: f = 11'h7FF;
        endcase
        return f;
    endfunction

    state_t        state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [1:0]    phase_r, phase_s;
    logic [10:0]   tx_r, tx_s;
    logic [7:0]    shift_r, shift_s;
    logic          rw_r;
    logic [7:0]    addr_r, wdata_r;
    logic          lat_s;
    logic          ss_n_r, ss_n_s;
    logic          mosi_r, mosi_s;
    logic          rsp_valid_r, rsp_valid_s;
    logic [7:0]    rsp_rdata_r, rsp_rdata_s;
    logic          busy_r, ready_r;
    logic          abort_s;

`ifdef SPI_RAM_MASTER_ABORT_EN
    assign abort_s = abort & (state_r != IDLE);
`else
    assign abort_s = 1'b0;
`endif

    // Next-state, serial outputs and response capture for the transaction sequencer.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        phase_s     = phase_r;
        tx_s        = tx_r;
        shift_s     = shift_r;
        lat_s       = 1'b0;
        ss_n_s      = ss_n_r;
        mosi_s      = mosi_r;
        rsp_valid_s = 1'b0;
        rsp_rdata_s = rsp_rdata_r;
        if (abort_s) begin
            state_s = IDLE;
            cnt_s   = '0;
            phase_s = PH_ADDR;
            ss_n_s  = 1'b1;
            mosi_s  = 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    ss_n_s = 1'b1;
                    mosi_s = 1'b1;
                    if (req_valid) begin
                        state_s = SEND;
                        cnt_s   = '0;
                        phase_s = PH_ADDR;
                        lat_s   = 1'b1;
                        tx_s    = build_frame(req_rw, PH_ADDR, req_addr, req_wdata);
                        ss_n_s  = 1'b0;
                    end else begin
                        cnt_s = '0;
                    end
                end
                SEND: begin
                    if (cnt_r < CW'(SEND_LAST)) begin
                        cnt_s  = cnt_r + CW'(1);
                        mosi_s = tx_r[10];
                        tx_s   = {tx_r[9:0], 1'b1};
                    end else begin
                        state_s = GAP;
                        cnt_s   = '0;
                        ss_n_s  = 1'b1;
                        mosi_s  = 1'b1;
                    end
                end
                GAP: begin
                    if (cnt_r < CW'(GAP_LAST)) begin
                        cnt_s = cnt_r + CW'(1);
                    end else if (phase_r == PH_ADDR) begin
                        state_s = SEND;
                        cnt_s   = '0;
                        phase_s = PH_DATA;
                        tx_s    = build_frame(rw_r, PH_DATA, addr_r, wdata_r);
                        ss_n_s  = 1'b0;
                    end else if (rw_r) begin
                        state_s = RESP;
                        cnt_s   = '0;
                        phase_s = PH_RESP;
                        ss_n_s  = 1'b0;
                    end else begin
                        state_s = IDLE;
                        cnt_s   = '0;
                        phase_s = PH_ADDR;
                    end
                end
                RESP: begin
                    mosi_s = 1'b1;
                    // MISO is only meaningful inside the 8-edge capture window.
                    if ((cnt_r >= CW'(MISO_DLY)) && (cnt_r <= CW'(MISO_DLY + 7))) begin
                        shift_s = {shift_r[6:0], MISO};
                    end else begin
                        shift_s = shift_r;
                    end
                    if (cnt_r < CW'(RESP_LAST)) begin
                        cnt_s = cnt_r + CW'(1);
                    end else begin
                        state_s = DONE;
                        cnt_s   = '0;
                        ss_n_s  = 1'b1;
                    end
                end
                DONE: begin
                    state_s     = IDLE;
                    phase_s     = PH_ADDR;
                    rsp_valid_s = 1'b1;
                    rsp_rdata_s = shift_r;
                end
                default: begin
                    state_s = IDLE;
                    cnt_s   = '0;
                    phase_s = PH_ADDR;
                    ss_n_s  = 1'b1;
                    mosi_s  = 1'b1;
                end
            endcase
        end
    end

    // State, request latch and registered host/SPI outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            phase_r     <= PH_ADDR;
            tx_r        <= 11'h7FF;
            shift_r     <= 8'h00;
            rw_r        <= 1'b0;
            addr_r      <= 8'h00;
            wdata_r     <= 8'h00;
            ss_n_r      <= 1'b1;
            mosi_r      <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 8'h00;
            busy_r      <= 1'b0;
            ready_r     <= 1'b1;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            phase_r     <= phase_s;
            tx_r        <= tx_s;
            shift_r     <= shift_s;
            ss_n_r      <= ss_n_s;
            mosi_r      <= mosi_s;
            rsp_valid_r <= rsp_valid_s;
            rsp_rdata_r <= rsp_rdata_s;
            busy_r      <= (state_s != IDLE);
            ready_r     <= (state_s == IDLE);
            if (lat_s) begin
                rw_r    <= req_rw;
                addr_r  <= req_addr;
                wdata_r <= req_wdata;
            end else begin
                rw_r    <= rw_r;
                addr_r  <= addr_r;
                wdata_r <= wdata_r;
            end
        end
    end

    assign SS_n      = ss_n_r;
    assign MOSI      = mosi_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign busy      = busy_r;
    assign req_ready = ready_r;
endmodule

// File: tb/tb_spi_ram_master.sv
// Bench for spi_ram_master: two instances (default and GAP=1/MISO_DLY=2) against a frame-level slave model.
// Abort steps are built only when SPI_RAM_MASTER_ABORT_EN is defined.
module tb_spi_ram_master;
    logic       clk;
    logic       rst;
    logic       req_valid [2];
    logic       req_ready [2];
    logic       req_rw    [2];
    logic [7:0] req_addr  [2];
    logic [7:0] req_wdata [2];
    logic       rsp_valid [2];
    logic [7:0] rsp_rdata [2];
    logic       busy      [2];
    logic       ss_n      [2];
    logic       mosi      [2];
    logic       miso      [2];
`ifdef SPI_RAM_MASTER_ABORT_EN
    logic       abort     [2];
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0]  ref_ram [2][256];
    logic [7:0]  slv_ram [2][256];
    logic [10:0] q0 [$];
    logic [10:0] q1 [$];
    bit          model_en  [2];
    int          low_cnt   [2];
    int          high_cnt  [2];
    bit          in_resp   [2];
    bit          exp_resp  [2];
    bit          mid_txn   [2];
    logic [10:0] sh        [2];
    logic [7:0]  s_addr    [2];
    logic [7:0]  resp_byte [2];
    int          n_pulse   [2];
    int          exp_pulse [2];

    spi_ram_master #(.GAP_CYCLES(2), .MISO_DLY(1)) u_dut0 (
        .clk(clk), .rst(rst),
`ifdef SPI_RAM_MASTER_ABORT_EN
        .abort(abort[0]),
`endif
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_rw(req_rw[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]),
        .rsp_rdata(rsp_rdata[0]), .busy(busy[0]), .SS_n(ss_n[0]), .MOSI(mosi[0]), .MISO(miso[0])
    );

    spi_ram_master #(.GAP_CYCLES(1), .MISO_DLY(2)) u_dut1 (
        .clk(clk), .rst(rst),
`ifdef SPI_RAM_MASTER_ABORT_EN
        .abort(abort[1]),
`endif
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_rw(req_rw[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]),
        .rsp_rdata(rsp_rdata[1]), .busy(busy[1]), .SS_n(ss_n[1]), .MOSI(mosi[1]), .MISO(miso[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int gap_of(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    function automatic int dly_of(input int k);
        return (k == 0) ? 1 : 2;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Slave model: collects frames while SS_n is low, checks them, and serves the response byte.
    always @(negedge clk) begin
        int          r;
        int          qs;
        logic [10:0] expf;
        logic [7:0]  rb;
        for (int k = 0; k < 2; k++) begin
            if (!model_en[k]) begin
                low_cnt[k] = 0; high_cnt[k] = 0; in_resp[k] = 1'b0;
                exp_resp[k] = 1'b0; mid_txn[k] = 1'b0; miso[k] = 1'b1;
            end else begin
                if (rsp_valid[k]) n_pulse[k]++;
                if (ss_n[k] == 1'b0) begin
                    if (low_cnt[k] == 0) begin
                        if (mid_txn[k]) chk($sformatf("gap_len%0d", k), high_cnt[k], gap_of(k));
                        in_resp[k] = exp_resp[k];
                    end
                    low_cnt[k]++;
                    if (in_resp[k] || low_cnt[k] == 1) chk($sformatf("mosi_one%0d", k), mosi[k], 1);
                    else sh[k] = {sh[k][9:0], mosi[k]};
                    r  = low_cnt[k] - 1;
                    rb = resp_byte[k];
                    if (in_resp[k] && r >= dly_of(k) && r <= dly_of(k) + 7) miso[k] = rb[7 - (r - dly_of(k))];
                    else miso[k] = 1'($urandom);
                end else begin
                    if (low_cnt[k] != 0) begin
                        if (in_resp[k]) begin
                            chk($sformatf("resp_len%0d", k), low_cnt[k], dly_of(k) + 9);
                            exp_resp[k] = 1'b0; mid_txn[k] = 1'b0; in_resp[k] = 1'b0;
                        end else begin
                            chk($sformatf("frame_len%0d", k), low_cnt[k], 12);
                            expf = 11'h000;
                            if (k == 0) begin qs = q0.size(); if (qs > 0) expf = q0.pop_front(); end
                            else begin qs = q1.size(); if (qs > 0) expf = q1.pop_front(); end
                            chk($sformatf("frame_queued%0d", k), qs > 0, 1);
                            chk($sformatf("frame_bits%0d", k), sh[k], expf);
                            case (sh[k][10:8])
                                3'b000:  begin s_addr[k] = sh[k][7:0]; mid_txn[k] = 1'b1; end
                                3'b001:  begin slv_ram[k][s_addr[k]] = sh[k][7:0]; mid_txn[k] = 1'b0; end
                                3'b110:  begin s_addr[k] = sh[k][7:0]; mid_txn[k] = 1'b1; end
                                3'b111:  begin exp_resp[k] = 1'b1; resp_byte[k] = slv_ram[k][s_addr[k]]; mid_txn[k] = 1'b1; end
                                default: mid_txn[k] = 1'b0;
                            endcase
                        end
                        high_cnt[k] = 1;
                    end else begin
                        high_cnt[k]++;
                    end
                    low_cnt[k] = 0;
                    miso[k] = 1'($urandom);
                end
            end
        end
    end

    task automatic issue(input int k, input bit rw, input logic [7:0] a, input logic [7:0] d, input bit wait_ready);
        int w;
        w = 0;
        if (wait_ready) while (!req_ready[k] && w < 400) begin @(negedge clk); w++; end
        req_valid[k] = 1'b1; req_rw[k] = rw; req_addr[k] = a; req_wdata[k] = d;
        if (rw) begin
            if (k == 0) begin q0.push_back({3'b110, a}); q0.push_back(11'h7FF); end
            else begin q1.push_back({3'b110, a}); q1.push_back(11'h7FF); end
        end else begin
            if (k == 0) begin q0.push_back({3'b000, a}); q0.push_back({3'b001, d}); end
            else begin q1.push_back({3'b000, a}); q1.push_back({3'b001, d}); end
            ref_ram[k][a] = d;
        end
    endtask

    task automatic accept(input int k);
        @(posedge clk); #1;
        req_valid[k] = 1'b0; req_addr[k] = 8'($urandom); req_wdata[k] = 8'($urandom); req_rw[k] = 1'($urandom);
        chk($sformatf("busy_acc%0d", k), busy[k], 1);
        chk($sformatf("ready_acc%0d", k), req_ready[k], 0);
    endtask

    task automatic follow(input int k, input bit rw, input logic [7:0] exp_data);
        int n, lat, seen, at;
        lat = 2 * (12 + gap_of(k)) + (rw ? dly_of(k) + 10 : 0);
        n = 0; seen = 0; at = 0;
        while (busy[k] && n < 400) begin
            @(posedge clk); #1; n++;
            if (rsp_valid[k]) begin seen++; at = n; chk($sformatf("rsp_data%0d", k), rsp_rdata[k], exp_data); end
        end
        chk($sformatf("latency%0d_rw%0d", k, rw), n, lat);
        chk($sformatf("ready_idle%0d", k), req_ready[k], 1);
        if (rw) begin
            chk($sformatf("rsp_pulses%0d", k), seen, 1);
            chk($sformatf("rsp_at%0d", k), at, lat);
            exp_pulse[k]++;
        end else begin
            chk($sformatf("wr_no_rsp%0d", k), seen, 0);
        end
    endtask

    task automatic run(input int k, input bit rw, input logic [7:0] a, input logic [7:0] d);
        logic [7:0] exp;
        exp = ref_ram[k][a];
        issue(k, rw, a, d, 1'b1);
        accept(k);
        follow(k, rw, exp);
        if (rw) begin
            @(posedge clk); #1;
            chk($sformatf("rsp_single%0d", k), rsp_valid[k], 0);
            chk($sformatf("rsp_hold%0d", k), rsp_rdata[k], exp);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int seen;
        logic [7:0] v;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 1'b0; req_rw[k] = 1'b0; req_addr[k] = 8'h00; req_wdata[k] = 8'h00;
            model_en[k] = 1'b0; n_pulse[k] = 0; exp_pulse[k] = 0; miso[k] = 1'b1;
`ifdef SPI_RAM_MASTER_ABORT_EN
            abort[k] = 1'b0;
`endif
            for (int a = 0; a < 256; a++) begin
                v = 8'($urandom); ref_ram[k][a] = v; slv_ram[k][a] = v;
            end
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_ss_n", ss_n[k], 1);
            chk("rst_mosi", mosi[k], 1);
            chk("rst_ready", req_ready[k], 1);
            chk("rst_busy", busy[k], 0);
            chk("rst_rsp_valid", rsp_valid[k], 0);
            chk("rst_rsp_rdata", rsp_rdata[k], 8'h00);
        end
        rst = 1'b0;
        model_en[0] = 1'b1; model_en[1] = 1'b1;

        // Directed write then read at 55h.
        run(0, 1'b0, 8'h55, 8'hAA);
        run(0, 1'b1, 8'h55, 8'h00);
        chk("read_55", rsp_rdata[0], 8'hAA);

        // Reset in the middle of a read-address frame.
        model_en[0] = 1'b0;
        issue(0, 1'b1, 8'h55, 8'h00, 1'b1);
        accept(0);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_ss_n", ss_n[0], 1);
        chk("midrst_mosi", mosi[0], 1);
        chk("midrst_busy", busy[0], 0);
        chk("midrst_ready", req_ready[0], 1);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        repeat (45) begin
            @(posedge clk); #1;
            if (rsp_valid[0] || !ss_n[0] || busy[0]) seen++;
        end
        chk("midrst_quiet", seen, 0);
        chk("midrst_rdata", rsp_rdata[0], 8'h00);
        q0.delete();
        model_en[0] = 1'b1;

        // Back-to-back with req_valid held high.
        issue(0, 1'b0, 8'h0F, 8'h3C, 1'b1);
        @(posedge clk); #1;
        chk("b2b_busy", busy[0], 1);
        issue(0, 1'b1, 8'h0F, 8'h00, 1'b0);
        follow(0, 1'b0, 8'h00);
        @(posedge clk); #1;
        chk("b2b_accept", busy[0], 1);
        req_valid[0] = 1'b0;
        follow(0, 1'b1, 8'h3C);

        // Swept parameters on the second instance.
        run(1, 1'b0, 8'h81, 8'hC3);
        run(1, 1'b1, 8'h81, 8'h00);
        chk("read_c3", rsp_rdata[1], 8'hC3);

`ifdef SPI_RAM_MASTER_ABORT_EN
        // Abort at bit F5 of the read-data frame, then abort in IDLE alongside a new read.
        begin
            logic [7:0] prev;
            prev = rsp_rdata[0];
            model_en[0] = 1'b0;
            issue(0, 1'b1, 8'h55, 8'h00, 1'b1);
            accept(0);
            repeat (18) @(posedge clk);
            #1;
            chk("abort_f5_low", ss_n[0], 0);
            abort[0] = 1'b1;
            @(posedge clk); #1;
            abort[0] = 1'b0;
            chk("abort_ss_n", ss_n[0], 1);
            chk("abort_mosi", mosi[0], 1);
            chk("abort_busy", busy[0], 0);
            seen = 0;
            repeat (45) begin
                @(posedge clk); #1;
                if (rsp_valid[0] || !ss_n[0]) seen++;
            end
            chk("abort_quiet", seen, 0);
            chk("abort_rdata", rsp_rdata[0], prev);
            q0.delete();
            model_en[0] = 1'b1;
            @(negedge clk);
            abort[0] = 1'b1;
            issue(0, 1'b1, 8'h55, 8'h00, 1'b1);
            accept(0);
            abort[0] = 1'b0;
            follow(0, 1'b1, 8'hAA);
        end
`endif

        // Randomised traffic over a small address window so reads hit earlier writes.
        for (int i = 0; i < 12; i++) begin
            run(i % 2, 1'($urandom), 8'($urandom_range(0, 7)), 8'($urandom));
        end

        repeat (4) @(posedge clk);
        #1;
        chk("pulses0", n_pulse[0], exp_pulse[0]);
        chk("pulses1", n_pulse[1], exp_pulse[1]);
        chk("frames_left0", q0.size(), 0);
        chk("frames_left1", q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
